// File: rtl/unidade_controle_jogo_if.sv
// Signal bundle between the game control unit and its surroundings (game top and datapath).
interface unidade_controle_jogo_if;
    logic       iniciar;
    logic       nivel;
    logic       jogada;
    logic       igual;
    logic [3:0] endereco;
    logic       zera_endereco;
    logic       conta_endereco;
    logic       zera_registrador;
    logic       registra_jogada;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic [3:0] db_estado;
    logic       db_nivel;
    logic       db_meioTempo;
    logic       db_fimTempo;

    modport master (
        input  iniciar, nivel, jogada, igual, endereco,
        output zera_endereco, conta_endereco, zera_registrador, registra_jogada,
        output acertou, errou, pronto, db_estado, db_nivel, db_meioTempo, db_fimTempo
    );

    modport slave (
        output iniciar, nivel, jogada, igual, endereco,
        input  zera_endereco, conta_endereco, zera_registrador, registra_jogada,
        input  acertou, errou, pronto, db_estado, db_nivel, db_meioTempo, db_fimTempo
    );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory-sequence game: round sequencing, level latch and per-play timeout.
// Outputs are registered decodes of the next state so they line up with the state register.
module unidade_controle_jogo #(
    parameter int unsigned TIMEOUT        = 5000,
    parameter int unsigned LIMITE_FACIL   = 7,
    parameter int unsigned LIMITE_DIFICIL = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_jogo_if.master bus
);
    localparam int unsigned TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_FIM  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MEIO = TW'(TIMEOUT / 2);
    localparam logic [3:0]    END_FACIL   = 4'(LIMITE_FACIL);
    localparam logic [3:0]    END_DIFICIL = 4'(LIMITE_DIFICIL);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_JOGADA = 4'h2,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROXIMO       = 4'h6,
        FIM_ACERTOU   = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERROU     = 4'hE
    } estado_t;

    estado_t       estado, estado_next;
    logic [TW-1:0] timer, timer_next;
    logic          nivel_reg, nivel_next;
    logic [3:0]    limite;

    logic zera_endereco_q, conta_endereco_q, zera_registrador_q, registra_jogada_q;
    logic acertou_q, errou_q, pronto_q, meio_tempo_q, fim_tempo_q;
    logic zera_endereco_d, conta_endereco_d, zera_registrador_d, registra_jogada_d;
    logic acertou_d, errou_d, pronto_d, meio_tempo_d, fim_tempo_d;

    assign limite = nivel_reg ? END_DIFICIL : END_FACIL;

    // State, timer, level latch and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado             <= INICIAL;
            timer              <= '0;
            nivel_reg          <= 1'b0;
            zera_endereco_q    <= 1'b0;
            conta_endereco_q   <= 1'b0;
            zera_registrador_q <= 1'b0;
            registra_jogada_q  <= 1'b0;
            acertou_q          <= 1'b0;
            errou_q            <= 1'b0;
            pronto_q           <= 1'b0;
            meio_tempo_q       <= 1'b0;
            fim_tempo_q        <= 1'b0;
        end else begin
            estado             <= estado_next;
            timer              <= timer_next;
            nivel_reg          <= nivel_next;
            zera_endereco_q    <= zera_endereco_d;
            conta_endereco_q   <= conta_endereco_d;
            zera_registrador_q <= zera_registrador_d;
            registra_jogada_q  <= registra_jogada_d;
            acertou_q          <= acertou_d;
            errou_q            <= errou_d;
            pronto_q           <= pronto_d;
            meio_tempo_q       <= meio_tempo_d;
            fim_tempo_q        <= fim_tempo_d;
        end
    end

    // Next state, timer and level; outputs decoded from the next state
    always_comb begin
        estado_next        = estado;
        timer_next         = timer;
        nivel_next         = nivel_reg;
        zera_endereco_d    = 1'b0;
        conta_endereco_d   = 1'b0;
        zera_registrador_d = 1'b0;
        registra_jogada_d  = 1'b0;
        acertou_d          = 1'b0;
        errou_d            = 1'b0;
        pronto_d           = 1'b0;
        meio_tempo_d       = 1'b0;
        fim_tempo_d        = 1'b0;

        case (estado)
            INICIAL, FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                if (bus.iniciar) begin
                    estado_next = PREPARACAO;
                    nivel_next  = bus.nivel;
                end
            end
            PREPARACAO: begin
                timer_next  = '0;
                estado_next = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // A play landing on the last timer cycle still counts
                if (bus.jogada)
                    estado_next = REGISTRA;
                else if (timer == TIMER_FIM)
                    estado_next = FIM_TIMEOUT;
                else
                    timer_next = timer + TW'(1);
            end
            REGISTRA: begin
                timer_next  = '0;
                estado_next = COMPARACAO;
            end
            COMPARACAO: begin
                if (!bus.igual)
                    estado_next = FIM_ERROU;
                else if (bus.endereco == limite)
                    estado_next = FIM_ACERTOU;
                else
                    estado_next = PROXIMO;
            end
            PROXIMO: begin
                timer_next  = '0;
                estado_next = ESPERA_JOGADA;
            end
            default: estado_next = INICIAL;
        endcase

        case (estado_next)
            PREPARACAO: begin
                zera_endereco_d    = 1'b1;
                zera_registrador_d = 1'b1;
            end
            ESPERA_JOGADA: meio_tempo_d = (timer_next >= TIMER_MEIO);
            REGISTRA:      registra_jogada_d = 1'b1;
            PROXIMO:       conta_endereco_d  = 1'b1;
            FIM_ACERTOU: begin
                pronto_d  = 1'b1;
                acertou_d = 1'b1;
            end
            FIM_ERROU: begin
                pronto_d = 1'b1;
                errou_d  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto_d     = 1'b1;
                errou_d      = 1'b1;
                meio_tempo_d = 1'b1;
                fim_tempo_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.zera_endereco    = zera_endereco_q;
    assign bus.conta_endereco   = conta_endereco_q;
    assign bus.zera_registrador = zera_registrador_q;
    assign bus.registra_jogada  = registra_jogada_q;
    assign bus.acertou          = acertou_q;
    assign bus.errou            = errou_q;
    assign bus.pronto           = pronto_q;
    assign bus.db_estado        = 4'(estado);
    assign bus.db_nivel         = nivel_reg;
    assign bus.db_meioTempo     = meio_tempo_q;
    assign bus.db_fimTempo      = fim_tempo_q;
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for the game control unit: table of per-cycle vectors plus timeout/reset sequences.
module tb_unidade_controle_jogo;
    logic clk;
    logic reset;

    unidade_controle_jogo_if bus ();

    unidade_controle_jogo dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {zera_end, conta_end, zera_reg, registra, acertou, errou, pronto, db_nivel, meio, fim}
    localparam logic [9:0] F_NONE  = 10'b0000000000;
    localparam logic [9:0] F_PREP  = 10'b1010000000;
    localparam logic [9:0] F_CONTA = 10'b0100000000;
    localparam logic [9:0] F_REG   = 10'b0001000000;
    localparam logic [9:0] F_WIN   = 10'b0000101000;
    localparam logic [9:0] F_ERR   = 10'b0000011000;
    localparam logic [9:0] F_NIV   = 10'b0000000100;
    localparam logic [9:0] F_MEIO  = 10'b0000000010;
    localparam logic [9:0] F_TO    = 10'b0000011011;

    typedef struct {
        logic       iniciar;
        logic       nivel;
        logic       jogada;
        logic       igual;
        logic [3:0] endereco;
        logic [3:0] est;
        logic [9:0] flg;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic ini, input logic niv, input logic jog,
                                input logic igu, input logic [3:0] ende,
                                input logic [3:0] est, input logic [9:0] flg);
        vec_t v;
        v.iniciar = ini; v.nivel = niv; v.jogada = jog; v.igual = igu;
        v.endereco = ende; v.est = est; v.flg = flg;
        vecs.push_back(v);
    endfunction

    function automatic logic [9:0] flags_dut();
        return {bus.zera_endereco, bus.conta_endereco, bus.zera_registrador,
                bus.registra_jogada, bus.acertou, bus.errou, bus.pronto,
                bus.db_nivel, bus.db_meioTempo, bus.db_fimTempo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ini, input logic niv, input logic jog,
                          input logic igu, input logic [3:0] ende);
        bus.iniciar = ini; bus.nivel = niv; bus.jogada = jog;
        bus.igual = igu; bus.endereco = ende;
    endtask

    task automatic chk(input string nm, input logic [3:0] est, input logic [9:0] flg);
        logic [9:0] f;
        f = flags_dut();
        n_checks++;
        if (bus.db_estado !== est) begin
            n_fail++;
            $display("FAIL %s: db_estado got %h expected %h", nm, bus.db_estado, est);
        end
        n_checks++;
        if (f !== flg) begin
            n_fail++;
            $display("FAIL %s: flags got %b expected %b", nm, f, flg);
        end
    endtask

    initial begin
        int bad;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 4'd0);
        tick();
        tick();
        chk("reset", 4'h0, F_NONE);
        reset = 1'b1;

        // Easy round: eight correct plays at addresses 0..7
        add(1, 0, 0, 0, 4'd0, 4'h1, F_PREP);
        add(0, 0, 0, 0, 4'd0, 4'h2, F_NONE);
        for (int i = 0; i < 8; i++) begin
            add(0, 0, 1, 0, 4'(i), 4'h4, F_REG);
            add(0, 0, 0, 0, 4'(i), 4'h5, F_NONE);
            if (i < 7) begin
                add(0, 0, 0, 1, 4'(i), 4'h6, F_CONTA);
                add(0, 0, 0, 0, 4'(i), 4'h2, F_NONE);
            end else begin
                add(0, 0, 0, 1, 4'(i), 4'hA, F_WIN);
            end
        end
        add(0, 1, 1, 1, 4'd7, 4'hA, F_WIN);
        // Hard round started from fim_acertou; nivel input dropped afterwards
        add(1, 1, 0, 0, 4'd0, 4'h1, F_PREP | F_NIV);
        add(0, 0, 0, 0, 4'd0, 4'h2, F_NIV);
        for (int i = 0; i < 9; i++) begin
            add(0, 0, 1, 0, 4'(i), 4'h4, F_REG | F_NIV);
            add(0, 0, 0, 0, 4'(i), 4'h5, F_NIV);
            if (i < 8) begin
                add(0, 0, 0, 1, 4'(i), 4'h6, F_CONTA | F_NIV);
                add(0, 0, 0, 0, 4'(i), 4'h2, F_NIV);
            end else begin
                add(0, 0, 0, 0, 4'(i), 4'hE, F_ERR | F_NIV);
            end
        end
        add(0, 0, 1, 1, 4'd8, 4'hE, F_ERR | F_NIV);

        foreach (vecs[k]) begin
            set_in(vecs[k].iniciar, vecs[k].nivel, vecs[k].jogada, vecs[k].igual, vecs[k].endereco);
            tick();
            chk($sformatf("vec%0d", k), vecs[k].est, vecs[k].flg);
        end

        // Timeout: no play at all
        set_in(1, 0, 0, 0, 4'd0);
        tick();
        chk("to_prep", 4'h1, F_PREP);
        set_in(0, 0, 0, 0, 4'd0);
        tick();
        chk("to_espera", 4'h2, F_NONE);
        repeat (2499) tick();
        chk("to_pre_meio", 4'h2, F_NONE);
        tick();
        chk("to_meio", 4'h2, F_MEIO);
        repeat (2499) tick();
        chk("to_last", 4'h2, F_MEIO);
        tick();
        chk("to_fim", 4'hD, F_TO);
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        chk("to_hold", 4'hD, F_TO);

        // Play on the final timer cycle wins over timeout
        set_in(1, 0, 0, 0, 4'd0);
        tick();
        chk("edge_prep", 4'h1, F_PREP);
        set_in(0, 0, 0, 0, 4'd0);
        tick();
        repeat (4999) tick();
        chk("edge_last", 4'h2, F_MEIO);
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        chk("edge_registra", 4'h4, F_REG);
        tick();
        chk("edge_comp", 4'h5, F_NONE);
        set_in(0, 0, 0, 1, 4'd0);
        tick();
        chk("edge_prox", 4'h6, F_CONTA);
        set_in(0, 0, 0, 0, 4'd0);
        tick();
        chk("edge_espera", 4'h2, F_NONE);

        // Reset in the middle of a wait
        repeat (3000) tick();
        chk("rst_pre", 4'h2, F_MEIO);
        reset = 1'b0;
        tick();
        chk("rst_abort", 4'h0, F_NONE);
        reset = 1'b1;
        bad = 0;
        repeat (5010) begin
            tick();
            if (bus.db_estado !== 4'h0 || flags_dut() !== F_NONE) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_idle: %0d non-idle cycles, expected 0", bad);
        end
        set_in(1, 1, 0, 0, 4'd0);
        tick();
        chk("rst_restart", 4'h1, F_PREP | F_NIV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
